// File: rtl/alu_issue_decoder_pkg.sv
// Shared encodings for the execute-stage issue block: ALU op codes, MIPS
// opcode/funct values, and the issue-entry record carried through the buffer.
package alu_issue_decoder_pkg;

  localparam int NB_DATA   = 32;
  localparam int NB_ALU_OP = 6;
  localparam int NB_INSTR  = 32;
  localparam int NB_CNT    = 8;

  // ALU op codes; these must stay byte-identical to the ALU's own encodings.
  localparam logic [NB_ALU_OP-1:0] ALU_SLL     = 6'b000000;
  localparam logic [NB_ALU_OP-1:0] ALU_SRL     = 6'b000010;
  localparam logic [NB_ALU_OP-1:0] ALU_SRA     = 6'b000011;
  localparam logic [NB_ALU_OP-1:0] ALU_SLLV    = 6'b000100;
  localparam logic [NB_ALU_OP-1:0] ALU_SRLV    = 6'b000110;
  localparam logic [NB_ALU_OP-1:0] ALU_SRAV    = 6'b000111;
  localparam logic [NB_ALU_OP-1:0] ALU_JMP     = 6'b001001;
  localparam logic [NB_ALU_OP-1:0] ALU_LUI     = 6'b001111;
  localparam logic [NB_ALU_OP-1:0] ALU_ADDU    = 6'b100001;
  localparam logic [NB_ALU_OP-1:0] ALU_SUBU    = 6'b100011;
  localparam logic [NB_ALU_OP-1:0] ALU_AND     = 6'b100100;
  localparam logic [NB_ALU_OP-1:0] ALU_OR      = 6'b100101;
  localparam logic [NB_ALU_OP-1:0] ALU_XOR     = 6'b100110;
  localparam logic [NB_ALU_OP-1:0] ALU_NOR     = 6'b100111;
  localparam logic [NB_ALU_OP-1:0] ALU_SLT     = 6'b101010;
  localparam logic [NB_ALU_OP-1:0] ALU_ILLEGAL = 6'b111111;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_JAL   = 6'b000011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_ADDIU = 6'b001001;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_XORI  = 6'b001110;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_LB    = 6'b100000;
  localparam logic [5:0] OPC_LH    = 6'b100001;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_LBU   = 6'b100100;
  localparam logic [5:0] OPC_LHU   = 6'b100101;
  localparam logic [5:0] OPC_SB    = 6'b101000;
  localparam logic [5:0] OPC_SH    = 6'b101001;
  localparam logic [5:0] OPC_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  typedef struct packed {
    logic [NB_ALU_OP-1:0] op;
    logic [NB_DATA-1:0]   a;
    logic [NB_DATA-1:0]   b;
    logic                 illegal;
  } issue_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } buf_state_t;

endpackage

// File: rtl/alu_issue_decoder_if.sv
// Issue-side bus: instruction intake from ID and decoded operands toward EX.
interface alu_issue_decoder_if;
  import alu_issue_decoder_pkg::*;

  logic                 i_valid;
  logic                 o_ready;
  logic [NB_INSTR-1:0]  i_instruction;
  logic [NB_DATA-1:0]   i_rs_data;
  logic [NB_DATA-1:0]   i_rt_data;
  logic [NB_DATA-1:0]   i_pc;
  logic                 i_flush;
  logic                 o_valid;
  logic                 i_ready;
  logic [NB_ALU_OP-1:0] o_alu_op;
  logic [NB_DATA-1:0]   o_dato_a;
  logic [NB_DATA-1:0]   o_dato_b;
  logic                 o_illegal;
  logic [NB_CNT-1:0]    o_illegal_count;

  modport slave (
    input  i_valid, i_instruction, i_rs_data, i_rt_data, i_pc, i_flush, i_ready,
    output o_ready, o_valid, o_alu_op, o_dato_a, o_dato_b, o_illegal, o_illegal_count
  );

  modport master (
    output i_valid, i_instruction, i_rs_data, i_rt_data, i_pc, i_flush, i_ready,
    input  o_ready, o_valid, o_alu_op, o_dato_a, o_dato_b, o_illegal, o_illegal_count
  );
endinterface

// File: rtl/alu_issue_decoder_decode.sv
// Combinational MIPS instruction decode into one ALU issue entry (op + operands).
module alu_op_decode
  import alu_issue_decoder_pkg::*;
(
  input  logic [NB_INSTR-1:0] instruction,
  input  logic [NB_DATA-1:0]  rs_data,
  input  logic [NB_DATA-1:0]  rt_data,
  input  logic [NB_DATA-1:0]  pc,
  output issue_entry_t        entry
);

  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic [NB_DATA-1:0] imm_se;
  logic [NB_DATA-1:0] imm_ze;
  logic [NB_DATA-1:0] shamt_ze;
  logic [NB_DATA-1:0] rs_shift;
  logic               unused_reg_fields;

  assign opcode   = instruction[31:26];
  assign funct    = instruction[5:0];
  assign imm_se   = {{(NB_DATA-16){instruction[15]}}, instruction[15:0]};
  assign imm_ze   = {{(NB_DATA-16){1'b0}}, instruction[15:0]};
  assign shamt_ze = NB_DATA'(instruction[10:6]);
  assign rs_shift = NB_DATA'(rs_data[4:0]);
  // Register numbers arrive already resolved as rs_data/rt_data.
  assign unused_reg_fields = ^instruction[25:16];

  always_comb begin
    // NOTE: assigning a full default first keeps every path driven, so no latch is inferred.
    entry = '{op: ALU_ILLEGAL, a: '0, b: '0, illegal: 1'b1};
    unique case (opcode)
      OPC_RTYPE: begin
        unique case (funct)
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT:
            entry = '{op: funct, a: rs_data, b: rt_data, illegal: 1'b0};
          FN_SLL, FN_SRL, FN_SRA:
            entry = '{op: funct, a: shamt_ze, b: rt_data, illegal: 1'b0};
          FN_SLLV, FN_SRLV, FN_SRAV:
            entry = '{op: funct, a: rs_shift, b: rt_data, illegal: 1'b0};
          FN_JR:   entry = '{op: ALU_ADDU, a: rs_data, b: '0, illegal: 1'b0};
          FN_JALR: entry = '{op: ALU_JMP,  a: pc,      b: '0, illegal: 1'b0};
          default: ;
        endcase
      end
      OPC_ADDIU, OPC_LB, OPC_LH, OPC_LW, OPC_LBU, OPC_LHU, OPC_SB, OPC_SH, OPC_SW:
        entry = '{op: ALU_ADDU, a: rs_data, b: imm_se, illegal: 1'b0};
      OPC_SLTI: entry = '{op: ALU_SLT, a: rs_data, b: imm_se, illegal: 1'b0};
      OPC_ANDI: entry = '{op: ALU_AND, a: rs_data, b: imm_ze, illegal: 1'b0};
      OPC_ORI:  entry = '{op: ALU_OR,  a: rs_data, b: imm_ze, illegal: 1'b0};
      OPC_XORI: entry = '{op: ALU_XOR, a: rs_data, b: imm_ze, illegal: 1'b0};
      OPC_LUI:  entry = '{op: ALU_LUI, a: '0,      b: imm_ze, illegal: 1'b0};
      OPC_BEQ, OPC_BNE:
        entry = '{op: ALU_SUBU, a: rs_data, b: rt_data, illegal: 1'b0};
      OPC_J:    entry = '{op: ALU_ADDU, a: '0, b: '0, illegal: 1'b0};
      OPC_JAL:  entry = '{op: ALU_JMP,  a: pc, b: '0, illegal: 1'b0};
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_decoder.sv
// ID->EX issue block: decodes instructions and holds up to two entries
// (head + skid) behind valid/ready handshakes, with flush and illegal counting.
module alu_issue_decoder
  import alu_issue_decoder_pkg::*;
(
  input  logic          i_clock,
  input  logic          i_reset_n,
  alu_issue_decoder_if.slave bus
);

  issue_entry_t      dec;
  issue_entry_t      head;
  issue_entry_t      skid;
  buf_state_t        state;
  logic              valid_q;
  logic              ready_q;
  logic [NB_CNT-1:0] illegal_cnt;
  logic              accept;
  logic              pop;

  alu_op_decode u_decode (
    .instruction (bus.i_instruction),
    .rs_data     (bus.i_rs_data),
    .rt_data     (bus.i_rt_data),
    .pc          (bus.i_pc),
    .entry       (dec)
  );

  assign accept = bus.i_valid & ready_q & ~bus.i_flush;
  assign pop    = valid_q & bus.i_ready;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= ST_EMPTY;
      valid_q     <= 1'b0;
      ready_q     <= 1'b1;
      // NOTE: the entry registers are reset too because head drives the outputs directly.
      head        <= '0;
      skid        <= '0;
      illegal_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      if (accept && dec.illegal && (illegal_cnt != '1))
        illegal_cnt <= illegal_cnt + 1'b1;

      if (bus.i_flush) begin
        state   <= ST_EMPTY;
        valid_q <= 1'b0;
        ready_q <= 1'b1;
      end else begin
        unique case (state)
          ST_EMPTY: begin
            if (accept) begin
              head    <= dec;
              state   <= ST_ONE;
              valid_q <= 1'b1;
            end
          end
          ST_ONE: begin
            if (accept && !pop) begin
              skid    <= dec;
              state   <= ST_FULL;
              ready_q <= 1'b0;
            end else if (accept && pop) begin
              head <= dec;
            end else if (pop) begin
              state   <= ST_EMPTY;
              valid_q <= 1'b0;
            end
          end
          ST_FULL: begin
            // ready_q is low here, so only the pop side can move.
            if (pop) begin
              head    <= skid;
              state   <= ST_ONE;
              ready_q <= 1'b1;
            end
          end
          default: begin
            state   <= ST_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.o_valid         = valid_q;
  assign bus.o_ready         = ready_q;
  assign bus.o_alu_op        = head.op;
  assign bus.o_dato_a        = head.a;
  assign bus.o_dato_b        = head.b;
  assign bus.o_illegal       = head.illegal;
  assign bus.o_illegal_count = illegal_cnt;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Randomized bench for alu_issue_decoder against a queue-based reference model.
module tb_alu_issue_decoder;
  import alu_issue_decoder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_decoder_if bus ();

  alu_issue_decoder dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  int tests = 0;
  int fails = 0;

  issue_entry_t q[$];
  int           model_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference decode straight from the instruction table, using raw codes.
  function automatic issue_entry_t ref_decode(input logic [31:0] ins, input logic [31:0] rs,
                                              input logic [31:0] rt, input logic [31:0] pc);
    logic [5:0]   opc = ins[31:26];
    logic [5:0]   fn  = ins[5:0];
    logic [31:0]  se  = {{16{ins[15]}}, ins[15:0]};
    logic [31:0]  ze  = {16'h0, ins[15:0]};
    issue_entry_t r   = '{op: 6'h3f, a: 32'h0, b: 32'h0, illegal: 1'b1};
    if (opc == 6'h00) begin
      if (fn inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a})
        r = '{op: fn, a: rs, b: rt, illegal: 1'b0};
      else if (fn inside {6'h00, 6'h02, 6'h03})
        r = '{op: fn, a: 32'(ins[10:6]), b: rt, illegal: 1'b0};
      else if (fn inside {6'h04, 6'h06, 6'h07})
        r = '{op: fn, a: rs % 32, b: rt, illegal: 1'b0};
      else if (fn == 6'h08)
        r = '{op: 6'h21, a: rs, b: 32'h0, illegal: 1'b0};
      else if (fn == 6'h09)
        r = '{op: 6'h09, a: pc, b: 32'h0, illegal: 1'b0};
    end else if (opc inside {6'h09, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b})
      r = '{op: 6'h21, a: rs, b: se, illegal: 1'b0};
    else if (opc == 6'h0a) r = '{op: 6'h2a, a: rs, b: se, illegal: 1'b0};
    else if (opc == 6'h0c) r = '{op: 6'h24, a: rs, b: ze, illegal: 1'b0};
    else if (opc == 6'h0d) r = '{op: 6'h25, a: rs, b: ze, illegal: 1'b0};
    else if (opc == 6'h0e) r = '{op: 6'h26, a: rs, b: ze, illegal: 1'b0};
    else if (opc == 6'h0f) r = '{op: 6'h0f, a: 32'h0, b: ze, illegal: 1'b0};
    else if (opc inside {6'h04, 6'h05}) r = '{op: 6'h23, a: rs, b: rt, illegal: 1'b0};
    else if (opc == 6'h02) r = '{op: 6'h21, a: 32'h0, b: 32'h0, illegal: 1'b0};
    else if (opc == 6'h03) r = '{op: 6'h09, a: pc, b: 32'h0, illegal: 1'b0};
    return r;
  endfunction

  task automatic compare_all();
    check("valid", 64'(bus.o_valid), 64'(q.size() > 0));
    check("ready", 64'(bus.o_ready), 64'(q.size() < 2));
    check("count", 64'(bus.o_illegal_count), 64'(model_cnt));
    if (q.size() > 0) begin
      check("op",      64'(bus.o_alu_op),  64'(q[0].op));
      check("dato_a",  64'(bus.o_dato_a),  64'(q[0].a));
      check("dato_b",  64'(bus.o_dato_b),  64'(q[0].b));
      check("illegal", 64'(bus.o_illegal), 64'(q[0].illegal));
    end
  endtask

  // One clock: drive inputs, advance past the edge, update model, compare.
  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] rs,
                      input logic [31:0] rt, input logic [31:0] pc,
                      input bit rdy, input bit fl, output bit accepted);
    issue_entry_t e;
    bit           pop;
    bus.i_valid = v; bus.i_instruction = ins; bus.i_rs_data = rs;
    bus.i_rt_data = rt; bus.i_pc = pc; bus.i_ready = rdy; bus.i_flush = fl;
    e        = ref_decode(ins, rs, rt, pc);
    accepted = v && (q.size() < 2) && !fl;
    pop      = (q.size() > 0) && rdy;
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (accepted) q.push_back(e);
    end
    if (accepted && e.illegal && model_cnt < 255) model_cnt++;
    compare_all();
  endtask

  task automatic idle(input bit rdy);
    bit acc;
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, rdy, 1'b0, acc);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] opcs [19] = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h09, 6'h0a,
                             6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h20, 6'h21, 6'h23, 6'h28, 6'h2b, 6'h3f};
    logic [5:0] fns [15]  = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                             6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a};
    logic [31:0] w = $urandom;
    if ($urandom_range(0, 9) != 0) w[31:26] = opcs[$urandom_range(0, 18)];
    if ($urandom_range(0, 9) != 0) w[5:0]   = fns[$urandom_range(0, 14)];
    return w;
  endfunction

  initial begin
    bit          acc;
    logic [31:0] ins;
    bus.i_valid = 0; bus.i_instruction = 0; bus.i_rs_data = 0; bus.i_rt_data = 0;
    bus.i_pc = 0; bus.i_ready = 1; bus.i_flush = 0;

    #12;
    check("rst_valid", 64'(bus.o_valid), 64'd0);
    check("rst_ready", 64'(bus.o_ready), 64'd1);
    check("rst_op",    64'(bus.o_alu_op), 64'd0);
    check("rst_a",     64'(bus.o_dato_a), 64'd0);
    check("rst_b",     64'(bus.o_dato_b), 64'd0);
    check("rst_ill",   64'(bus.o_illegal), 64'd0);
    check("rst_cnt",   64'(bus.o_illegal_count), 64'd0);
    rst_n = 1'b1;

    // addiu with imm -1
    step(1, {6'h09, 5'd1, 5'd2, 16'hFFFF}, 32'd5, 32'd0, 32'd0, 1, 0, acc);
    check("addiu_op", 64'(bus.o_alu_op), 64'h21);
    check("addiu_a",  64'(bus.o_dato_a), 64'd5);
    check("addiu_b",  64'(bus.o_dato_b), 64'hFFFFFFFF);
    check("addiu_il", 64'(bus.o_illegal), 64'd0);

    // sra shamt=4 then srav with rs=0x24
    step(1, {6'h00, 5'd1, 5'd2, 5'd3, 5'd4, 6'h03}, 32'h0, 32'h80000000, 32'h0, 1, 0, acc);
    check("sra_op", 64'(bus.o_alu_op), 64'h03);
    check("sra_a",  64'(bus.o_dato_a), 64'd4);
    check("sra_b",  64'(bus.o_dato_b), 64'h80000000);
    step(1, {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h07}, 32'h24, 32'h80000000, 32'h0, 1, 0, acc);
    check("srav_op", 64'(bus.o_alu_op), 64'h07);
    check("srav_a",  64'(bus.o_dato_a), 64'd4);
    check("srav_b",  64'(bus.o_dato_b), 64'h80000000);
    idle(1);

    // stall with three instructions, then drain
    step(1, {6'h0d, 5'd1, 5'd2, 16'h1234}, 32'hA0, 32'h0, 32'h0, 0, 0, acc);
    step(1, {6'h0a, 5'd1, 5'd2, 16'h8000}, 32'hB0, 32'h0, 32'h0, 0, 0, acc);
    check("stall_ready", 64'(bus.o_ready), 64'd0);
    step(1, {6'h04, 5'd1, 5'd2, 16'h0}, 32'hC0, 32'hC1, 32'h0, 0, 0, acc);
    check("stall_head_b", 64'(bus.o_dato_b), 64'h1234);
    acc = 0;
    for (int i = 0; i < 10 && !acc; i++)
      step(1, {6'h04, 5'd1, 5'd2, 16'h0}, 32'hC0, 32'hC1, 32'h0, 1, 0, acc);
    check("third_accepted", 64'(acc), 64'd1);
    idle(1); idle(1); idle(1);

    // lui and jal
    step(1, {6'h0f, 5'd0, 5'd2, 16'hABCD}, 32'h0, 32'h0, 32'h0, 1, 0, acc);
    check("lui_op", 64'(bus.o_alu_op), 64'h0f);
    check("lui_b",  64'(bus.o_dato_b), 64'h0000ABCD);
    step(1, {6'h03, 26'h10}, 32'h0, 32'h0, 32'h100, 1, 0, acc);
    check("jal_op", 64'(bus.o_alu_op), 64'h09);
    check("jal_a",  64'(bus.o_dato_a), 64'h100);
    check("jal_b",  64'(bus.o_dato_b), 64'h0);
    idle(1);

    // flush while FULL with a valid input
    step(1, rand_instr(), $urandom, $urandom, $urandom, 0, 0, acc);
    step(1, rand_instr(), $urandom, $urandom, $urandom, 0, 0, acc);
    step(1, rand_instr(), $urandom, $urandom, $urandom, 0, 1, acc);
    check("flush_valid", 64'(bus.o_valid), 64'd0);
    check("flush_ready", 64'(bus.o_ready), 64'd1);
    idle(1);
    check("flush_gone", 64'(bus.o_valid), 64'd0);

    // illegal saturation
    for (int i = 0; i < 300; i++) begin
      ins = {6'h3f, 26'($urandom)};
      step(1, ins, $urandom, $urandom, $urandom, 1, 0, acc);
    end
    check("sat_count", 64'(bus.o_illegal_count), 64'd255);
    check("sat_op",    64'(bus.o_alu_op), 64'h3f);
    idle(1);

    // async reset mid-stream
    step(1, rand_instr(), $urandom, $urandom, $urandom, 0, 0, acc);
    step(1, rand_instr(), $urandom, $urandom, $urandom, 0, 0, acc);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(bus.o_valid), 64'd0);
    check("arst_ready", 64'(bus.o_ready), 64'd1);
    check("arst_count", 64'(bus.o_illegal_count), 64'd0);
    q.delete();
    model_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0, acc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_issue_decoder.md
# alu_issue_decoder

Execute-stage issue block that produces the operation code and both operands consumed by the 32-bit ALU. It takes a MIPS instruction with its register-file values and PC, decodes it into the ALU opcode encoding, and selects and extends operands A and B. Results are held in a 2-entry buffer with valid/ready handshakes on both sides, so the block can sit between ID and EX while supporting stalls and flushes.

## Interface
- NB_DATA, 32, operand/data width
- NB_ALU_OP, 6, ALU op width
- NB_INSTR, 32, instruction width
- NB_CNT, 8, illegal-instruction counter width
- i_clock  in  1  single clock, rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_valid  in  1  upstream instruction valid
- o_ready  out  1  block can accept (registered)
- i_instruction  in  NB_INSTR  MIPS instruction word
- i_rs_data, i_rt_data  in  NB_DATA  register-file values
- i_pc  in  NB_DATA  PC of the instruction
- i_flush  in  1  discard all buffered and incoming entries
- o_valid  out  1  head entry valid
- i_ready  in  1  ALU/EX side accepts head
- o_alu_op  out  NB_ALU_OP  ALU op code
- o_dato_a, o_dato_b  out  NB_DATA  ALU operands
- o_illegal  out  1  head entry was an unsupported encoding
- o_illegal_count  out  NB_CNT  saturating count of accepted illegal instructions

## Operation
- ALU op codes:
  - addu 100001, subu 100011, and 100100, or 100101, xor 100110, nor 100111, slt 101010
  - sll 000000, srl 000010, sra 000011, sllv 000100, srlv 000110, srav 000111
  - lui 001111, jmp 001001, illegal 111111; 111111 makes the ALU output 0.
- Immediate extension: SE = sign-extended imm[15:0]; ZE = zero-extended.
- R-type (opcode 000000), by funct:
  - addu/subu/and/or/xor/nor/slt: op = funct, A = rs, B = rt.
  - sll/srl/sra: op = funct, A = ZE(shamt), B = rt.
  - sllv/srlv/srav: op = funct, A = ZE(rs[4:0]), B = rt.
  - jr 001000: addu, A = rs, B = 0.
  - jalr 001001: jmp, A = pc, B = 0.
- I-type:
  - addiu 001001: addu, A = rs, B = SE.
  - slti 001010: slt, A = rs, B = SE.
  - andi/ori/xori 001100/001101/001110: and/or/xor, A = rs, B = ZE.
  - lui 001111: lui, A = 0, B = ZE.
  - Loads/stores 100000, 100001, 100011, 100100, 100101, 101000, 101001, 101011: addu, A = rs, B = SE.
  - beq/bne 000100/000101: subu, A = rs, B = rt.
- J-type: j 000010 gives addu, A = 0, B = 0. jal 000011 gives jmp, A = pc, B = 0.
- Any other encoding: op 111111, A = B = 0, o_illegal = 1.
- Buffer: head register plus skid register. States are EMPTY, ONE, FULL.
  - Accept when i_valid & o_ready & !i_flush.
  - Pop when o_valid & i_ready.
  - EMPTY + accept → ONE.
  - ONE + accept + !pop → FULL.
  - ONE + pop + !accept → EMPTY.
  - ONE + accept + pop → ONE; the new entry becomes head.
  - FULL + pop → ONE; the skid entry moves to head. No accept is possible in FULL.
- o_ready = (state != FULL), registered.
- i_flush: next state EMPTY and o_valid = 0. The same-cycle input is not accepted. o_illegal_count is not cleared.
- o_illegal_count increments on every accepted illegal instruction and saturates at 2^NB_CNT−1. Only reset clears it.

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - State EMPTY; o_valid = 0; o_ready = 1.
  - o_alu_op = 0, o_dato_a = 0, o_dato_b = 0, o_illegal = 0, o_illegal_count = 0.
- Latency: an instruction accepted at edge N is on the outputs with o_valid = 1 after edge N.
- Throughput: 1 instruction per cycle while i_ready = 1.
- Stall: head outputs stay stable while o_valid & !i_ready.
- o_ready falls the cycle after the second unpopped entry is accepted, and rises the cycle after a pop from FULL.
- Reset mid-operation: all entries are dropped immediately. No partial entry survives.
- Decode is combinational on the inputs; only registered values drive the outputs. No output depends combinationally on i_ready or i_flush.

## Structure
- Shared package holds:
  - ALU op localparams, which must be byte-identical to the ALU's encodings.
  - MIPS opcode/funct constants.
  - An issue-entry struct {op, a, b, illegal}.
- Sub-module alu_op_decode: purely combinational instruction → entry. The parent owns the buffer, state and counter.

## Test plan
- Reset with i_ready = 1; issue addiu $t, $s, −1 with rs = 5 → after 1 cycle: op 100001, A = 5, B = 0xFFFFFFFF, o_illegal = 0.
- Issue sra with shamt = 4 and rt = 0x80000000, then srav with rs = 0x24 → op 000011 with A = 4; then op 000111 with A = 4 (rs[4:0]); B = 0x80000000 in both.
- Hold i_ready = 0 and present 3 valid instructions → first two accepted, o_ready = 0 after the second, head stable. Release i_ready → entries emerge in order; third accepted after first pop.
- Issue lui imm 0xABCD and jal with pc = 0x100 → op 001111 with B = 0x0000ABCD; op 001001 with A = 0x100, B = 0.
- Buffer FULL, assert i_flush together with i_valid → next cycle o_valid = 0, o_ready = 1, incoming entry never appears.
- Issue 300 illegal opcodes (e.g. 111111) → o_illegal = 1 with op 111111 each; counter saturates at 255. Async reset mid-stream → count 0, o_valid = 0 immediately.
